retire_packer: RTL and testbench

RETIRE_PACKER -- requirements
Module: retire_packer

---
 rtl/mure_pkg.sv | 23 ++
 rtl/retire_packer.sv | 146 ++++++++++++++
 tb/tb_retire_packer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mure_pkg.sv
// rtl/mure_pkg.sv - shared retire-path types: uop slot count, itype encoding, uop entry
// Contents:
//   NrRetiredInstr : number of uop slots in one retire group
//   itype_e        : retired uop class (STD, EXC, INT, ERET, UJ)
//   uop_entry_s    : one retired uop as carried through the packer
package mure_pkg;

    localparam int NrRetiredInstr = 4;

    typedef enum logic [2:0] {
        STD  = 3'd0,
        EXC  = 3'd1,
        INT  = 3'd2,
        ERET = 3'd3,
        UJ   = 3'd4
    } itype_e;

    typedef struct packed {
        itype_e      itype;
        logic [31:0] pc;
    } uop_entry_s;

endpackage

// File: rtl/retire_packer.sv
// rtl/retire_packer.sv - packs retired uops into groups of up to NrRetiredInstr slots
// Ports:
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   valid_i, uop_i, ready_o   : upstream uop offer / accept (ready_o = not sealed)
//   flush_i                   : seal a partial group now
//   valid_o, uop_[a..d]_o     : presented group, A oldest
//   ivalids_o                 : slot-valid mask, MSB = A
//   pop_i                     : consumer took the presented group
module retire_packer #(
    parameter int NrRetiredInstr = mure_pkg::NrRetiredInstr,
    parameter int TimeoutCycles  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    input  mure_pkg::uop_entry_s       uop_i,
    output logic                       ready_o,
    input  logic                       flush_i,
    output logic                       valid_o,
    output mure_pkg::uop_entry_s       uop_a_o,
    output mure_pkg::uop_entry_s       uop_b_o,
    output mure_pkg::uop_entry_s       uop_c_o,
    output mure_pkg::uop_entry_s       uop_d_o,
    output logic [NrRetiredInstr-1:0]  ivalids_o,
    input  logic                       pop_i
);

    localparam int CntW  = $clog2(NrRetiredInstr + 1);
    localparam int IdxW  = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;
    localparam int IdleW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_SEALED  = 2'd2
    } asm_state_e;

    asm_state_e                   state_q, state_d;
    logic [CntW-1:0]              count_q, count_d;
    logic [IdleW-1:0]             idle_q, idle_d;
    mure_pkg::uop_entry_s         slots_q [NrRetiredInstr];
    mure_pkg::uop_entry_s         slots_d [NrRetiredInstr];
    mure_pkg::uop_entry_s         grp_q   [NrRetiredInstr];
    mure_pkg::uop_entry_s         grp_d   [NrRetiredInstr];
    logic [NrRetiredInstr-1:0]    mask_q, mask_d;
    logic                         valid_q, valid_d;

    logic            accept;
    logic            transfer;
    logic [CntW-1:0] count_inc;

    // Contiguous mask from the top bit down: count n sets the n MSBs.
    function automatic logic [NrRetiredInstr-1:0] count_to_mask(input logic [CntW-1:0] n);
        logic [NrRetiredInstr-1:0] m;
        m = '0;
        for (int i = 0; i < NrRetiredInstr; i++) begin
            if (CntW'(i) < n) m[NrRetiredInstr-1-i] = 1'b1;
        end
        return m;
    endfunction

    assign ready_o   = (state_q != ST_SEALED);
    assign accept    = valid_i && ready_o;
    // A sealed group moves out whenever the output register is free or being freed.
    assign transfer  = (state_q == ST_SEALED) && (!valid_q || pop_i);
    assign count_inc = count_q + CntW'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idle_d  = idle_q;
        slots_d = slots_q;
        grp_d   = grp_q;
        mask_d  = mask_q;
        valid_d = valid_q;

        case (state_q)
            ST_EMPTY, ST_FILLING: begin
                if (accept) begin
                    slots_d[count_q[IdxW-1:0]] = uop_i;
                    count_d = count_inc;
                    idle_d  = '0;
                    // Non-STD uops close their group so they are always the last valid slot.
                    if ((count_inc == CntW'(NrRetiredInstr)) ||
                        (uop_i.itype != mure_pkg::STD) || flush_i) begin
                        state_d = ST_SEALED;
                    end else begin
                        state_d = ST_FILLING;
                    end
                end else if (state_q == ST_FILLING) begin
                    if (flush_i || (idle_q == IdleW'(TimeoutCycles - 1))) begin
                        state_d = ST_SEALED;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + IdleW'(1);
                    end
                end
            end
            default: ; // ST_SEALED waits for transfer below
        endcase

        if (transfer) begin
            grp_d   = slots_q;
            mask_d  = count_to_mask(count_q);
            valid_d = 1'b1;
            state_d = ST_EMPTY;
            count_d = '0;
            idle_d  = '0;
            for (int i = 0; i < NrRetiredInstr; i++) slots_d[i] = '0;
        end else if (pop_i && valid_q) begin
            valid_d = 1'b0;
            mask_d  = '0;
            for (int i = 0; i < NrRetiredInstr; i++) grp_d[i] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
            idle_q  <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < NrRetiredInstr; i++) begin
                slots_q[i] <= '0;
                grp_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idle_q  <= idle_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            slots_q <= slots_d;
            grp_q   <= grp_d;
        end
    end

    assign valid_o   = valid_q;
    assign ivalids_o = mask_q;
    assign uop_a_o   = grp_q[0];
    assign uop_b_o   = grp_q[1];
    assign uop_c_o   = grp_q[2];
    assign uop_d_o   = grp_q[3];

endmodule

// File: tb/tb_retire_packer.sv
// tb/tb_retire_packer.sv - self-checking bench for retire_packer
module tb_retire_packer;
    import mure_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       valid_i = 1'b0;
    uop_entry_s uop_i = '0;
    logic       ready_o;
    logic       flush_i = 1'b0;
    logic       valid_o;
    uop_entry_s uop_a_o, uop_b_o, uop_c_o, uop_d_o;
    logic [3:0] ivalids_o;
    logic       pop_i = 1'b1;

    retire_packer #(.NrRetiredInstr(4), .TimeoutCycles(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .uop_i(uop_i),
        .ready_o(ready_o), .flush_i(flush_i), .valid_o(valid_o),
        .uop_a_o(uop_a_o), .uop_b_o(uop_b_o), .uop_c_o(uop_c_o), .uop_d_o(uop_d_o),
        .ivalids_o(ivalids_o), .pop_i(pop_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] mask;
        uop_entry_s a, b, c, d;
    } grp_t;

    typedef struct {
        int         n;
        itype_e     last;
        int         mode;   // 0 self-seal, 1 flush with last uop, 2 timeout, 3 flush afterwards
        logic [3:0] mask;
    } vec_t;

    grp_t        exp_q[$];
    uop_entry_s  bld[4];
    int          bn = 0;
    logic [31:0] pc_ctr = 32'h1000;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_bld();
        for (int i = 0; i < 4; i++) bld[i] = '0;
        bn = 0;
    endtask

    task automatic push_grp(input logic [3:0] m);
        grp_t g;
        g.mask = m;
        g.a = bld[0];
        g.b = bld[1];
        g.c = bld[2];
        g.d = bld[3];
        exp_q.push_back(g);
        clr_bld();
    endtask

    task automatic send(input itype_e t, input logic fl);
        int b = 0;
        while (!ready_o && b < 20) begin
            tick();
            b++;
        end
        if (!ready_o) chk("send_ready_timeout", 64'(ready_o), 64'd1);
        valid_i = 1'b1;
        flush_i = fl;
        uop_i.itype = t;
        uop_i.pc = pc_ctr;
        if (bn < 4) bld[bn] = uop_i;
        bn++;
        tick();
        valid_i = 1'b0;
        flush_i = 1'b0;
        uop_i = '0;
        pc_ctr = pc_ctr + 32'd4;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!valid_o && cyc < 30) begin
            tick();
            cyc++;
        end
        if (!valid_o) chk("wait_valid_timeout", 64'(valid_o), 64'd1);
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() > 0 && b < 40) begin
            tick();
            b++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: compare each group at the moment the consumer takes it.
    always @(negedge clk) begin
        if (rst_ni && valid_o && pop_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_group", 64'(ivalids_o), 64'd0);
            end else begin
                grp_t e;
                e = exp_q.pop_front();
                chk("grp_mask", 64'(ivalids_o), 64'(e.mask));
                chk("grp_a", 64'(uop_a_o), 64'(e.a));
                chk("grp_b", 64'(uop_b_o), 64'(e.b));
                chk("grp_c", 64'(uop_c_o), 64'(e.c));
                chk("grp_d", 64'(uop_d_o), 64'(e.d));
            end
        end
    end

    vec_t tbl[8];

    initial begin
        int          cyc;
        logic [31:0] g1_pc, g2_pc;

        tbl[0] = '{4, STD,  0, 4'b1111};
        tbl[1] = '{2, UJ,   0, 4'b1100};
        tbl[2] = '{1, EXC,  0, 4'b1000};
        tbl[3] = '{3, STD,  1, 4'b1110};
        tbl[4] = '{1, STD,  2, 4'b1000};
        tbl[5] = '{3, INT,  0, 4'b1110};
        tbl[6] = '{2, STD,  3, 4'b1100};
        tbl[7] = '{4, ERET, 0, 4'b1111};
        clr_bld();

        #2;
        chk("rst_valid_o", 64'(valid_o), 64'd0);
        chk("rst_ivalids", 64'(ivalids_o), 64'd0);
        chk("rst_ready_o", 64'(ready_o), 64'd1);
        chk("rst_uop_a", 64'(uop_a_o), 64'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                send((j == tbl[i].n - 1) ? tbl[i].last : STD,
                     (tbl[i].mode == 1) && (j == tbl[i].n - 1));
            end
            if (tbl[i].mode == 3) begin
                flush_i = 1'b1;
                tick();
                flush_i = 1'b0;
            end
            push_grp(tbl[i].mask);
            drain();
        end

        // Four STD back-to-back: valid_o high for exactly one cycle.
        for (int j = 0; j < 4; j++) send(STD, 1'b0);
        push_grp(4'b1111);
        wait_valid(cyc);
        tick();
        chk("valid_one_cycle", 64'(valid_o), 64'd0);
        drain();

        // STD, UJ, STD: UJ closes group 1; trailing STD opens group 2 in slot A.
        send(STD, 1'b0);
        send(UJ, 1'b0);
        push_grp(4'b1100);
        send(STD, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        push_grp(4'b1000);
        drain();

        // Timeout: accept at edge N, seal at N+8, present after N+9.
        send(STD, 1'b0);
        push_grp(4'b1000);
        wait_valid(cyc);
        chk("timeout_latency", 64'(cyc), 64'd9);
        drain();

        // EXC into empty: ready_o low for one cycle.
        send(EXC, 1'b0);
        chk("exc_ready_low", 64'(ready_o), 64'd0);
        push_grp(4'b1000);
        tick();
        chk("exc_ready_back", 64'(ready_o), 64'd1);
        chk("exc_valid", 64'(valid_o), 64'd1);
        drain();

        // Back-pressure: group 1 held, group 2 sealed behind it.
        pop_i = 1'b0;
        g1_pc = pc_ctr;
        for (int j = 0; j < 4; j++) send(STD, 1'b0);
        push_grp(4'b1111);
        g2_pc = pc_ctr;
        for (int j = 0; j < 4; j++) send(STD, 1'b0);
        push_grp(4'b1111);
        tick();
        tick();
        chk("bp_ready_low", 64'(ready_o), 64'd0);
        chk("bp_valid_held", 64'(valid_o), 64'd1);
        chk("bp_g1_stable", 64'(uop_a_o.pc), 64'(g1_pc));
        pop_i = 1'b1;
        tick();
        chk("bp_g2_no_bubble", 64'(valid_o), 64'd1);
        chk("bp_g2_a", 64'(uop_a_o.pc), 64'(g2_pc));
        chk("bp_ready_back", 64'(ready_o), 64'd1);
        drain();

        // Reset with a presented group and a partial group of three.
        pop_i = 1'b0;
        send(EXC, 1'b0);
        clr_bld();
        wait_valid(cyc);
        for (int j = 0; j < 3; j++) send(STD, 1'b0);
        clr_bld();
        #3;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid_o", 64'(valid_o), 64'd0);
        chk("arst_ivalids", 64'(ivalids_o), 64'd0);
        chk("arst_uop_a", 64'(uop_a_o), 64'd0);
        chk("arst_ready_o", 64'(ready_o), 64'd1);
        tick();
        tick();
        rst_ni = 1'b1;
        pop_i = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("arst_no_stale", 64'(valid_o), 64'd0);
        send(STD, 1'b1);
        push_grp(4'b1000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
